// File: rtl/q_writeback.sv
// Q-table write-back stage: re-aligns {S, A} with Q_new through a LAT-deep delay line,
// queues writes in a small FIFO and issues them over valid/ready. Optional macro: QWB_COALESCE_EN.
module q_writeback #(
    parameter int L_WIDTH = 4,
    parameter int Q_WIDTH = 16,
    parameter int S_WIDTH = 8,
    parameter int LAT     = 2,
    parameter int FIFO_AW = 2,
    localparam int A_WIDTH    = 2 + L_WIDTH / 2,
    localparam int ADDR_WIDTH = S_WIDTH + A_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [S_WIDTH-1:0]    S,
    input  logic [A_WIDTH-1:0]    A,
    input  logic [Q_WIDTH-1:0]    Q_new,
    output logic                  wr_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [Q_WIDTH-1:0]    wr_data,
    input  logic                  wr_ready,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [15:0]           wr_count
);

    localparam int                 DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   C_DEPTH   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   C_CNT_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] C_PTR_ONE = FIFO_AW'(1);

    // Delay line: address side of each agent step, clocked every cycle
    logic [LAT-1:0]        r_dl_valid;
    logic [ADDR_WIDTH-1:0] r_dl_addr [LAT];
    logic                  w_tap_valid;
    logic [ADDR_WIDTH-1:0] w_tap_addr;

    // FIFO storage and bookkeeping
    logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
    logic [Q_WIDTH-1:0]    r_mem_data [DEPTH];
    logic [FIFO_AW-1:0]    r_wptr;
    logic [FIFO_AW-1:0]    r_rptr;
    logic [FIFO_AW:0]      r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;

    // Output request register
    logic                  r_wr_valid;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [Q_WIDTH-1:0]    r_wr_data;
    logic [15:0]           r_wr_count;

    logic                  w_fifo_nonempty;
    logic                  w_pop;
    logic                  w_coalesce;
    logic                  w_push;
    logic                  w_drop;
    logic [FIFO_AW:0]      w_count_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dl_valid <= '0;
        end else begin
            r_dl_valid[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                r_dl_valid[i] <= r_dl_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_dl_addr[0] <= {S, A};
        for (int i = 1; i < LAT; i++) begin
            r_dl_addr[i] <= r_dl_addr[i-1];
        end
    end

    assign w_tap_valid = r_dl_valid[LAT-1];
    assign w_tap_addr  = r_dl_addr[LAT-1];

    // Handshake: a request is transferred on a rising edge where wr_valid && wr_ready;
    // while wr_valid is high and wr_ready low, wr_addr/wr_data hold and wr_valid stays high.
    assign w_fifo_nonempty = (r_count != '0);
    assign w_pop           = w_fifo_nonempty && (!r_wr_valid || wr_ready);

`ifdef QWB_COALESCE_EN
    logic [FIFO_AW-1:0] w_last_ptr;
    assign w_last_ptr = r_wptr - C_PTR_ONE;
    // The newest entry can be merged only if it is not leaving for the output register this edge.
    assign w_coalesce = w_tap_valid && w_fifo_nonempty
                        && !(w_pop && (r_count == C_CNT_ONE))
                        && (r_mem_addr[w_last_ptr] == w_tap_addr);
`else
    assign w_coalesce = 1'b0;
`endif

    assign w_push = w_tap_valid && !w_coalesce && (!r_full || w_pop);
    assign w_drop = w_tap_valid && !w_coalesce && r_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + C_CNT_ONE;
            2'b01:   w_count_nxt = r_count - C_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= w_tap_addr;
            r_mem_data[r_wptr] <= Q_new;
        end
`ifdef QWB_COALESCE_EN
        else if (w_coalesce) begin
            r_mem_data[w_last_ptr] <= Q_new;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + C_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_DEPTH);
            r_empty <= (w_count_nxt == '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_count <= '0;
        end else begin
            if (r_wr_valid && wr_ready) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_pop) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_mem_addr[r_rptr];
                r_wr_data  <= r_mem_data[r_rptr];
            end else if (wr_ready) begin
                r_wr_valid <= 1'b0;
            end
        end
    end

    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign full     = r_full;
    assign empty    = r_empty;
    assign overflow = r_overflow;
    assign wr_count = r_wr_count;

endmodule

// File: doc/q_writeback.md
# q_writeback

Q-table write-back stage placed directly downstream of the agent. It pairs each updated Q-value (`Q_new`) with the state/action that produced it, several cycles earlier, and forms the Q-table address. It buffers the resulting writes in a small FIFO and issues them to the Q-table memory port over a valid/ready handshake. It also tracks dropped updates and the number of committed writes per episode.

## Interface
Parameters:
- `L_WIDTH`, 4: level-field width; duration part of the action is `L_WIDTH/2` bits.
- `Q_WIDTH`, 16: Q-value width, two's complement.
- `S_WIDTH`, 8: state index width.
- `LAT`, 2: cycles from action issue to matching `Q_new`; legal range 1..8.
- `FIFO_AW`, 2: FIFO depth is `2**FIFO_AW` entries.
- `A_WIDTH` (local), `2 + L_WIDTH/2`.
- `ADDR_WIDTH` (local), `S_WIDTH + A_WIDTH`.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: a new agent step is issued this cycle.
- `S`, in, S_WIDTH: current state index.
- `A`, in, A_WIDTH: action issued, `{A_dur, A_road}`.
- `Q_new`, in, Q_WIDTH: updated Q-value, aligned `LAT` cycles after `in_valid`.
- `wr_valid`, out, 1: the write request is valid.
- `wr_addr`, out, ADDR_WIDTH: `{S, A}` of the write.
- `wr_data`, out, Q_WIDTH: Q-value to write.
- `wr_ready`, in, 1: the memory accepts the request this cycle.
- `full`, out, 1: the FIFO holds `2**FIFO_AW` entries.
- `empty`, out, 1: the FIFO holds no entries.
- `overflow`, out, 1: sticky flag; at least one update was dropped.
- `wr_count`, out, 16: writes accepted by memory since reset; wraps at 2^16.

## Operation
- **Delay line.** `LAT` stages of `{valid, S, A}`, clocked every cycle regardless of backpressure. The tap at stage `LAT` carries the address matching the current `Q_new`.
- **Push.** When the tap is valid, `{tap_S, tap_A, Q_new}` is pushed into the FIFO.
- **Output stage.** A register drives `wr_valid`, `wr_addr` and `wr_data`.
  - It loads the FIFO head when the FIFO is not empty and either `wr_valid`=0 or `wr_ready`=1.
  - Otherwise it holds.
  - A request completes on an edge with `wr_valid && wr_ready`. `wr_count` increments on that edge.
- **Handshake rules.**
  - While `wr_valid`=1 and `wr_ready`=0, `wr_addr` and `wr_data` are stable.
  - `wr_valid` never drops without acceptance, except on reset.
- **Full FIFO.** A push and a pop in the same cycle while full are both performed, and the count is unchanged. A push while full with no pop drops the update and sets `overflow`. `overflow` clears only on reset.
- **Empty FIFO.** Push and load in the same cycle while empty: the entry goes into the FIFO this edge and loads into the output register on the next edge. There is no fall-through.
- **Pointers.** Read and write pointers wrap modulo `2**FIFO_AW`. `full` and `empty` are derived from an occupancy counter `0..2**FIFO_AW`.
- **Reset.** Reset mid-operation discards the delay line, the FIFO contents and any pending request; the interrupted request is not counted.

## Timing
- All outputs are registered.
- Reset values: `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `full`=0, `empty`=1, `overflow`=0, `wr_count`=0. All delay-line valid bits are 0.
- Latency:
  - `in_valid` is sampled at edge t.
  - `Q_new` is sampled and pushed at edge t+LAT.
  - `wr_valid` is high after edge t+LAT+1, assuming the FIFO was empty and the output register was free.
- Throughput is one write per cycle while `wr_ready`=1.
- `in_valid`, `S` and `A` are sampled every cycle; there is no backpressure to the agent.

## Configuration
- `QWB_COALESCE_EN`, when defined:
  - A push whose address equals the most recently pushed entry still in the FIFO overwrites that entry's data instead of adding a new entry.
  - Occupancy is unchanged, and this also applies when the FIFO is full, so no overflow occurs.
  - An entry already moved to the output register is never modified.
- When undefined, every push creates a new entry.

## Test plan
- **Basic latency.** `LAT`=2, `wr_ready`=1. Single `in_valid` at edge 0 with `S`=8'h05, `A`=4'hB; `Q_new`=16'h0123 at edge 2.
  - Required: `wr_valid` high after edge 3 for exactly one cycle, with `wr_addr`=12'h05B and `wr_data`=16'h0123.
  - Required: `wr_count`=1.
- **Backpressure and overflow.** `wr_ready`=0; 6 consecutive steps with distinct `S`=0..5.
  - Required: the output register holds S=0 and the FIFO holds S=1..4.
  - Required: `full`=1, the S=5 update is dropped, `overflow`=1.
  - Then `wr_ready`=1: addresses for S=0..4 appear in order, and `wr_count`=5.
- **Full with simultaneous push and pop.** With the FIFO full, raise `wr_ready` on the same cycle a push arrives.
  - Required: no drop, `overflow` stays 0, `full` stays 1.
- **Handshake stability.** Toggle `wr_ready` 1,0,0,1 during a stream of 4 writes.
  - Required: `wr_addr`/`wr_data` are unchanged while `wr_ready`=0, and no write is duplicated or skipped.
- **Reset mid-operation.** Assert `rst` for one cycle while 3 entries are queued.
  - Required: all outputs return to reset values on the next edge.
  - Required: no stale write appears afterwards.
- **Coalescing (`QWB_COALESCE_EN`).** `wr_ready`=0; push the same address 3 times with data 1, 2, 3.
  - Required: one FIFO entry, released with data 3 after the output register drains.
  - Without the macro: 3 writes with data 1, 2, 3.
